// File: rtl/ef_pin_mux_ctrl.sv
// Pin function-select controller for EF_PIN_MUX: serialises single-pin function
// changes and tristates the pin for a guard window around each select update.
module ef_pin_mux_ctrl #(
   parameter int COUNT = 16,
   parameter int GUARD = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [3:0]         cfg_pin,
   input  logic [1:0]         cfg_func,
   input  logic               lock_set,
   output logic [COUNT*2-1:0] sel,
   output logic [COUNT-1:0]   force_oeb,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               locked
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DRAIN  = 2'd1;
   localparam logic [1:0] SWITCH = 2'd2;
   localparam logic [1:0] SETTLE = 2'd3;
   localparam int CW = (GUARD > 1) ? $clog2(GUARD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(GUARD - 1);

   logic [1:0]         state_r;
   logic [CW-1:0]      cnt_r;
   logic [3:0]         pin_r;
   logic [1:0]         func_r;
   logic [COUNT*2-1:0] sel_r;
   logic [COUNT-1:0]   foeb_r;
   logic               done_r;
   logic               err_r;
   logic               locked_r;

   logic               pin_ok_s;
   logic [1:0]         cur_func_s;
   logic [COUNT-1:0]   onehot_s;

   // Decode the requested pin: range check, its current field, and its one-hot mask.
   always_comb begin
      pin_ok_s   = ({28'd0, cfg_pin} < 32'(COUNT));
      cur_func_s = 2'b00;
      onehot_s   = '0;
      for (int i = 0; i < COUNT; i++) begin
         cur_func_s  = (cfg_pin == 4'(i)) ? sel_r[2*i +: 2] : cur_func_s;
         onehot_s[i] = (cfg_pin == 4'(i));
      end
   end

   // Request classification, switch sequencing, lock and status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         cnt_r    <= '0;
         pin_r    <= 4'd0;
         func_r   <= 2'd0;
         sel_r    <= '0;
         foeb_r   <= '0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         locked_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         if (lock_set) begin
            locked_r <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (cfg_valid) begin
                  // A lock arriving on the same edge already rejects the request.
                  if (locked_r || lock_set) begin
                     err_r <= 1'b1;
                  end else if (!pin_ok_s) begin
                     err_r <= 1'b1;
                  end else if (cfg_func == cur_func_s) begin
                     done_r <= 1'b1;
                  end else begin
                     pin_r   <= cfg_pin;
                     func_r  <= cfg_func;
                     cnt_r   <= '0;
                     foeb_r  <= onehot_s;
                     state_r <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= '0;
                  state_r <= SWITCH;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            SWITCH: begin
               for (int i = 0; i < COUNT; i++) begin
                  if (pin_r == 4'(i)) begin
                     sel_r[2*i +: 2] <= func_r;
                  end
               end
               state_r <= SETTLE;
            end
            SETTLE: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= '0;
                  foeb_r  <= '0;
                  done_r  <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               cnt_r   <= '0;
               foeb_r  <= '0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign sel       = sel_r;
   assign force_oeb = foeb_r;
   assign busy      = (state_r != IDLE);
   assign cfg_ready = (state_r == IDLE);
   assign done      = done_r;
   assign err       = err_r;
   assign locked    = locked_r;

endmodule

// File: tb/tb_ef_pin_mux_ctrl.sv
// Bench for ef_pin_mux_ctrl: directed scenarios plus random traffic on two
// configurations, each checked every cycle against a cycle-index reference model.
module tb_ef_pin_mux_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cfg_valid = 1'b0;
   logic [3:0] cfg_pin = 4'd0;
   logic [1:0] cfg_func = 2'd0;
   logic lock_set = 1'b0;

   logic [31:0] sel0;
   logic [15:0] foeb0;
   logic ready0, busy0, done0, err0, locked0;
   logic [23:0] sel1;
   logic [11:0] foeb1;
   logic ready1, busy1, done1, err1, locked1;

   int checks = 0;
   int failures = 0;

   // model state per configuration (0: COUNT=16/GUARD=4, 1: COUNT=12/GUARD=2)
   int       k [2];
   int       mpin [2];
   int       mfunc [2];
   int       msel [2][16];
   bit       mlocked [2];
   bit       mdone [2];
   bit       merr [2];

   always #5 clk = ~clk;

   ef_pin_mux_ctrl #(.COUNT(16), .GUARD(4)) u_dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready0),
      .cfg_pin(cfg_pin), .cfg_func(cfg_func), .lock_set(lock_set),
      .sel(sel0), .force_oeb(foeb0), .busy(busy0), .done(done0),
      .err(err0), .locked(locked0));

   ef_pin_mux_ctrl #(.COUNT(12), .GUARD(2)) u_small (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready1),
      .cfg_pin(cfg_pin), .cfg_func(cfg_func), .lock_set(lock_set),
      .sel(sel1), .force_oeb(foeb1), .busy(busy1), .done(done1),
      .err(err1), .locked(locked1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input int m, input bit r, input bit v, input int p,
                             input int f, input bit ls);
      int g = (m == 0) ? 4 : 2;
      int n = (m == 0) ? 16 : 12;
      bit idle = (k[m] == 0);
      mdone[m] = 1'b0;
      merr[m]  = 1'b0;
      if (r) begin
         k[m] = 0;
         mlocked[m] = 1'b0;
         for (int i = 0; i < 16; i++) msel[m][i] = 0;
      end else begin
         if (idle) begin
            if (v) begin
               if (mlocked[m] || ls) merr[m] = 1'b1;
               else if (p >= n) merr[m] = 1'b1;
               else if (msel[m][p] == f) mdone[m] = 1'b1;
               else begin
                  k[m] = 1;
                  mpin[m] = p;
                  mfunc[m] = f;
               end
            end
         end else begin
            k[m] = k[m] + 1;
            if (k[m] == g + 2) msel[m][mpin[m]] = mfunc[m];
            if (k[m] == 2 * g + 2) begin
               mdone[m] = 1'b1;
               k[m] = 0;
            end
         end
         if (ls) mlocked[m] = 1'b1;
      end
   endtask

   task automatic compare_all();
      for (int m = 0; m < 2; m++) begin
         logic [31:0] esel = 32'd0;
         logic [31:0] efoeb = 32'd0;
         logic [31:0] asel, afoeb;
         logic a_ready, a_busy, a_done, a_err, a_locked;
         int n = (m == 0) ? 16 : 12;
         for (int i = 0; i < n; i++) esel = esel | (32'(msel[m][i]) << (2 * i));
         if (k[m] != 0) efoeb = 32'd1 << mpin[m];
         if (m == 0) begin
            asel = sel0; afoeb = {16'd0, foeb0};
            a_ready = ready0; a_busy = busy0; a_done = done0; a_err = err0; a_locked = locked0;
         end else begin
            asel = {8'd0, sel1}; afoeb = {20'd0, foeb1};
            a_ready = ready1; a_busy = busy1; a_done = done1; a_err = err1; a_locked = locked1;
         end
         check($sformatf("sel[%0d]", m), asel, esel);
         check($sformatf("force_oeb[%0d]", m), afoeb, efoeb);
         check($sformatf("cfg_ready[%0d]", m), {31'd0, a_ready}, {31'd0, k[m] == 0});
         check($sformatf("busy[%0d]", m), {31'd0, a_busy}, {31'd0, k[m] != 0});
         check($sformatf("done[%0d]", m), {31'd0, a_done}, {31'd0, mdone[m]});
         check($sformatf("err[%0d]", m), {31'd0, a_err}, {31'd0, merr[m]});
         check($sformatf("locked[%0d]", m), {31'd0, a_locked}, {31'd0, mlocked[m]});
         check($sformatf("oeb_onehot[%0d]", m), {31'd0, $countones(afoeb) <= 1}, 32'd1);
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [3:0] p,
                       input logic [1:0] f, input bit ls);
      rst = r; cfg_valid = v; cfg_pin = p; cfg_func = f; lock_set = ls;
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) model_step(m, r, v, int'(p), int'(f), ls);
      compare_all();
   endtask

   initial begin
      // reset
      step(1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      step(1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      check("lit_reset_sel", sel0, 32'd0);
      check("lit_reset_ready", {31'd0, ready0}, 32'd1);

      // single switch pin 5 -> func 2; cycle c follows the c-th edge after accept
      for (int c = 1; c <= 10; c++) begin
         step(1'b0, c == 1, 4'd5, 2'd2, 1'b0);
         if (c == 1) check("lit_sw_foeb_c1", {16'd0, foeb0}, 32'h0000_0020);
         if (c == 5) check("lit_sw_sel_c5", sel0, 32'd0);
         if (c == 6) check("lit_sw_sel_c6", sel0, 32'h0000_0800);
         if (c == 9) check("lit_sw_ready_c9", {31'd0, ready0}, 32'd0);
         if (c == 10) check("lit_sw_done_c10", {31'd0, done0}, 32'd1);
      end

      // no-op, then an out-of-range pin on the 12-pin instance
      step(1'b0, 1'b1, 4'd5, 2'd2, 1'b0);
      check("lit_noop_done", {31'd0, done0}, 32'd1);
      check("lit_noop_foeb", {16'd0, foeb0}, 32'd0);
      step(1'b0, 1'b1, 4'd13, 2'd1, 1'b0);
      check("lit_range_err_small", {31'd0, err1}, 32'd1);
      for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 4'd0, 2'd0, 1'b0);

      // reset in cycle 6 of a pin 0 -> func 3 switch
      for (int c = 1; c <= 7; c++) step(c == 7, c == 1, 4'd0, 2'd3, 1'b0);
      check("lit_midrst_sel", sel0, 32'd0);
      check("lit_midrst_done", {31'd0, done0}, 32'd0);
      step(1'b0, 1'b0, 4'd0, 2'd0, 1'b0);

      // back-to-back: pin 1 f1 then held pin 2 f3
      for (int c = 1; c <= 22; c++) begin
         if (c == 1) step(1'b0, 1'b1, 4'd1, 2'd1, 1'b0);
         else step(1'b0, c <= 11, 4'd2, 2'd3, 1'b0);
         if (c == 11) check("lit_b2b_foeb_c11", {16'd0, foeb0}, 32'h0000_0004);
         if (c == 16) check("lit_b2b_sel_c16", sel0, 32'h0000_0034);
      end

      // lock during SETTLE of pin 3 -> func 1
      for (int c = 1; c <= 10; c++) step(1'b0, c == 1, 4'd3, 2'd1, c == 7);
      check("lit_lock_sel", sel0, 32'h0000_0074);
      check("lit_lock_locked", {31'd0, locked0}, 32'd1);
      step(1'b0, 1'b1, 4'd3, 2'd0, 1'b0);
      check("lit_lock_err", {31'd0, err0}, 32'd1);
      step(1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      step(1'b0, 1'b1, 4'd4, 2'd1, 1'b1);
      check("lit_simul_err", {31'd0, err0}, 32'd1);
      check("lit_simul_locked", {31'd0, locked0}, 32'd1);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         step($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 299) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
